// File: rtl/kv_ledger_pkg.sv
// Shared opcodes, status codes and FSM encoding for the key/balance ledger stage.
package kv_ledger_pkg;

    localparam logic [1:0] OP_ISSUE    = 2'd0;
    localparam logic [1:0] OP_RSVD     = 2'd1;
    localparam logic [1:0] OP_TRANSFER = 2'd2;
    localparam logic [1:0] OP_REFER    = 2'd3;

    localparam logic [2:0] ST_OK           = 3'd0;
    localparam logic [2:0] ST_NOT_FOUND    = 3'd1;
    localparam logic [2:0] ST_EXISTS       = 3'd2;
    localparam logic [2:0] ST_FULL         = 3'd3;
    localparam logic [2:0] ST_INSUFFICIENT = 3'd4;
    localparam logic [2:0] ST_OVERFLOW     = 3'd5;
    localparam logic [2:0] ST_BAD_OP       = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEARCH,
        S_EXEC,
        S_RESP
    } state_t;

endpackage

// File: rtl/kv_ledger_scan.sv
// Linear-scan tracker: one ledger entry per cycle, remembers first hits for both keys
// and the lowest free slot.
module kv_ledger_scan
    import kv_ledger_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int KEY_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic [IDX_W-1:0] idx,
    input  logic             entry_valid,
    input  logic [KEY_W-1:0] entry_key,
    input  logic [KEY_W-1:0] key_a,
    input  logic [KEY_W-1:0] key_b,
    output logic             hit_a,
    output logic [IDX_W-1:0] idx_a,
    output logic             hit_b,
    output logic [IDX_W-1:0] idx_b,
    output logic             free,
    output logic [IDX_W-1:0] idx_free
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hit_a    <= 1'b0;
            idx_a    <= '0;
            hit_b    <= 1'b0;
            idx_b    <= '0;
            free     <= 1'b0;
            idx_free <= '0;
        end else if (clear) begin
            hit_a    <= 1'b0;
            idx_a    <= '0;
            hit_b    <= 1'b0;
            idx_b    <= '0;
            free     <= 1'b0;
            idx_free <= '0;
        end else if (en) begin
            // first match wins; indices are visited in ascending order
            if (entry_valid && entry_key == key_a && !hit_a) begin
                hit_a <= 1'b1;
                idx_a <= idx;
            end
            if (entry_valid && entry_key == key_b && !hit_b) begin
                hit_b <= 1'b1;
                idx_b <= idx;
            end
            if (!entry_valid && !free) begin
                free     <= 1'b1;
                idx_free <= idx;
            end
        end
    end

endmodule

// File: rtl/kv_ledger_exec.sv
// Ledger execution stage: scans all slots for each command, then applies ISSUE/TRANSFER/REFER
// in one EXEC cycle and holds the response until it is taken.
module kv_ledger_exec
    import kv_ledger_pkg::*;
#(
    parameter int NUM_ENTRIES = 16,
    parameter int KEY_W       = 16,
    parameter int VAL_W       = 32
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic [1:0]                         cmd_op,
    input  logic [KEY_W-1:0]                   cmd_key_a,
    input  logic [KEY_W-1:0]                   cmd_key_b,
    input  logic [VAL_W-1:0]                   cmd_amount,
    output logic                               resp_valid,
    input  logic                               resp_ready,
    output logic [2:0]                         resp_status,
    output logic [VAL_W-1:0]                   resp_value,
    output logic [$clog2(NUM_ENTRIES+1)-1:0]   occupancy
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int OCC_W = $clog2(NUM_ENTRIES + 1);

    state_t state, state_nx;

    logic [IDX_W-1:0] cnt;
    logic [1:0]       op_q;
    logic [KEY_W-1:0] key_a_q, key_b_q;
    logic [VAL_W-1:0] amt_q;

    logic [NUM_ENTRIES-1:0] ent_valid;
    logic [KEY_W-1:0]       ent_key [NUM_ENTRIES];
    logic [VAL_W-1:0]       ent_bal [NUM_ENTRIES];

    logic             hit_a, hit_b, free_found;
    logic [IDX_W-1:0] idx_a, idx_b, idx_free;
    logic             accept, scan_en, scan_last;

    logic [2:0]       ex_status;
    logic [VAL_W-1:0] ex_value, bal_a, bal_b;
    logic [VAL_W:0]   sum_b;
    logic             do_issue, do_xfer;

    assign accept    = cmd_valid && cmd_ready;
    assign scan_last = (cnt == IDX_W'(NUM_ENTRIES - 1));

    kv_ledger_scan #(.IDX_W(IDX_W), .KEY_W(KEY_W)) u_scan (
        .clock      (clock),
        .reset      (reset),
        .clear      (accept),
        .en         (scan_en),
        .idx        (cnt),
        .entry_valid(ent_valid[cnt]),
        .entry_key  (ent_key[cnt]),
        .key_a      (key_a_q),
        .key_b      (key_b_q),
        .hit_a      (hit_a),
        .idx_a      (idx_a),
        .hit_b      (hit_b),
        .idx_b      (idx_b),
        .free       (free_found),
        .idx_free   (idx_free)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (accept) state_nx = S_SEARCH;
            S_SEARCH: if (scan_last) state_nx = S_EXEC;
            S_EXEC:   state_nx = S_RESP;
            S_RESP:   if (resp_valid && resp_ready) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == S_IDLE);
        scan_en   = (state == S_SEARCH);
    end

    // Command evaluation against the scan results; only consumed in EXEC.
    always_comb begin
        ex_status = ST_OK;
        ex_value  = '0;
        do_issue  = 1'b0;
        do_xfer   = 1'b0;
        bal_a     = ent_bal[idx_a];
        bal_b     = ent_bal[idx_b];
        sum_b     = {1'b0, bal_b} + {1'b0, amt_q};
        case (op_q)
            OP_ISSUE: begin
                if (hit_a)            ex_status = ST_EXISTS;
                else if (!free_found) ex_status = ST_FULL;
                else begin
                    do_issue = 1'b1;
                    ex_value = amt_q;
                end
            end
            OP_REFER: begin
                if (!hit_a) ex_status = ST_NOT_FOUND;
                else        ex_value  = bal_a;
            end
            OP_TRANSFER: begin
                if (!hit_a || !hit_b)        ex_status = ST_NOT_FOUND;
                else if (bal_a < amt_q)      ex_status = ST_INSUFFICIENT;
                else if (key_a_q == key_b_q) ex_value  = bal_a;
                else if (sum_b[VAL_W])       ex_status = ST_OVERFLOW;
                else begin
                    do_xfer  = 1'b1;
                    ex_value = bal_a - amt_q;
                end
            end
            default: ex_status = ST_BAD_OP;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_q        <= '0;
            key_a_q     <= '0;
            key_b_q     <= '0;
            amt_q       <= '0;
            cnt         <= '0;
            ent_valid   <= '0;
            occupancy   <= '0;
            resp_status <= ST_OK;
            resp_value  <= '0;
            resp_valid  <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= cmd_op;
                key_a_q <= cmd_key_a;
                key_b_q <= cmd_key_b;
                amt_q   <= cmd_amount;
                cnt     <= '0;
            end else if (scan_en) begin
                cnt <= cnt + IDX_W'(1);
            end
            if (state == S_EXEC) begin
                resp_status <= ex_status;
                resp_value  <= ex_value;
                if (do_issue) begin
                    ent_valid[idx_free] <= 1'b1;
                    occupancy           <= occupancy + OCC_W'(1);
                end
            end
            // response register stage: valid rises one cycle after entering RESP
            if (state == S_RESP && !resp_valid)   resp_valid <= 1'b1;
            else if (resp_valid && resp_ready)    resp_valid <= 1'b0;
        end
    end

    // Key/balance payload needs no reset; the valid bits qualify it.
    always_ff @(posedge clock) begin
        if (state == S_EXEC) begin
            if (do_issue) begin
                ent_key[idx_free] <= key_a_q;
                ent_bal[idx_free] <= amt_q;
            end
            if (do_xfer) begin
                ent_bal[idx_a] <= bal_a - amt_q;
                ent_bal[idx_b] <= sum_b[VAL_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_kv_ledger_exec.sv
// Self-checking bench: directed ledger scenarios plus randomized commands against a key->balance model.
module tb_kv_ledger_exec;

    localparam int N = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [15:0] cmd_key_a = '0;
    logic [15:0] cmd_key_b = '0;
    logic [31:0] cmd_amount = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [2:0]  resp_status;
    logic [31:0] resp_value;
    logic [4:0]  occupancy;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    logic [31:0] m_bal [logic [15:0]];

    kv_ledger_exec #(.NUM_ENTRIES(N), .KEY_W(16), .VAL_W(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_key_a  (cmd_key_a),
        .cmd_key_b  (cmd_key_b),
        .cmd_amount (cmd_amount),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_status(resp_status),
        .resp_value (resp_value),
        .occupancy  (occupancy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: a map of key -> balance; slot placement is invisible from outside.
    task automatic model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] amt, output logic [2:0] st, output logic [31:0] val);
        longint unsigned s;
        st = 3'd0;
        val = '0;
        case (op)
            2'd0: begin
                if (m_bal.exists(a))      st = 3'd2;
                else if (m_bal.num() >= N) st = 3'd3;
                else begin
                    m_bal[a] = amt;
                    val = amt;
                end
            end
            2'd3: begin
                if (!m_bal.exists(a)) st = 3'd1;
                else val = m_bal[a];
            end
            2'd2: begin
                if (!m_bal.exists(a) || !m_bal.exists(b)) st = 3'd1;
                else if (m_bal[a] < amt) st = 3'd4;
                else if (a == b) val = m_bal[a];
                else begin
                    s = longint'(m_bal[b]) + longint'(amt);
                    if (s > 64'hFFFF_FFFF) st = 3'd5;
                    else begin
                        m_bal[a] = m_bal[a] - amt;
                        m_bal[b] = 32'(s);
                        val = m_bal[a];
                    end
                end
            end
            default: st = 3'd6;
        endcase
    endtask

    // While idle, occupancy must track the model and no response may be pending.
    always @(negedge clock) begin
        if (chk_en && !reset && cmd_ready) begin
            check("idle_occupancy", 32'(occupancy), 32'(m_bal.num()));
            check("idle_resp_valid", 32'(resp_valid), 32'd0);
        end
    end

    task automatic run_cmd(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] amt, input int hold,
                           output logic [2:0] got_st, output logic [31:0] got_val);
        logic [2:0]  est;
        logic [31:0] evl;
        int lat;
        got_st = '0;
        got_val = '0;
        @(negedge clock);
        lat = 0;
        while (!cmd_ready && lat < 200) begin
            @(negedge clock);
            lat++;
        end
        if (!cmd_ready) begin
            check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
            return;
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_key_a = a; cmd_key_b = b; cmd_amount = amt;
        resp_ready = 1'b0;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom); cmd_key_a = 16'($urandom); cmd_key_b = 16'($urandom);
        cmd_amount = $urandom;
        model(op, a, b, amt, est, evl);
        lat = 0;
        do begin
            @(posedge clock);
            #1;
            lat++;
        end while (!resp_valid && lat < 100);
        check("latency", 32'(lat), 32'(N + 2));
        if (!resp_valid) return;
        got_st = resp_status;
        got_val = resp_value;
        check("status", 32'(resp_status), 32'(est));
        check("value", resp_value, evl);
        for (int i = 0; i < hold; i++) begin
            @(posedge clock);
            #1;
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_status", 32'(resp_status), 32'(got_st));
            check("hold_value", resp_value, got_val);
            check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clock);
        #1;
        resp_ready = 1'b0;
        check("post_hs_valid", 32'(resp_valid), 32'd0);
        check("post_hs_ready", 32'(cmd_ready), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        m_bal.delete();
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic reset_mid_search(input logic [15:0] k, input int wait_cyc);
        @(negedge clock);
        while (!cmd_ready) @(negedge clock);
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_key_a = k; cmd_key_b = '0; cmd_amount = 32'd9;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < wait_cyc; i++) @(posedge clock);
        do_reset();
    endtask

    logic [2:0]  st;
    logic [31:0] val;

    initial begin
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_status", 32'(resp_status), 32'd0);
        check("rst_resp_value", resp_value, 32'd0);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        chk_en = 1'b1;

        run_cmd(2'd3, 16'h0117, 16'h0, 32'd0, 0, st, val);
        check("lit_refer_missing", 32'(st), 32'd1);
        check("lit_refer_missing_val", val, 32'd0);
        run_cmd(2'd0, 16'h0117, 16'h0, 32'd23, 0, st, val);
        check("lit_issue_a", 32'(st), 32'd0);
        run_cmd(2'd0, 16'h0013, 16'h0, 32'd0, 0, st, val);
        check("lit_issue_b", 32'(st), 32'd0);
        run_cmd(2'd2, 16'h0117, 16'h0013, 32'd20, 0, st, val);
        check("lit_xfer_st", 32'(st), 32'd0);
        check("lit_xfer_val", val, 32'd3);
        run_cmd(2'd3, 16'h0013, 16'h0, 32'd0, 0, st, val);
        check("lit_refer_dst", val, 32'd20);
        check("lit_occ2", 32'(occupancy), 32'd2);
        run_cmd(2'd2, 16'h0117, 16'h0013, 32'd100, 0, st, val);
        check("lit_insufficient", 32'(st), 32'd4);
        run_cmd(2'd3, 16'h0117, 16'h0, 32'd0, 0, st, val);
        check("lit_src_kept", val, 32'd3);
        run_cmd(2'd0, 16'h0117, 16'h0, 32'd5, 0, st, val);
        check("lit_exists", 32'(st), 32'd2);
        run_cmd(2'd0, 16'h0300, 16'h0, 32'hFFFF_FFFF, 0, st, val);
        run_cmd(2'd2, 16'h0117, 16'h0300, 32'd1, 0, st, val);
        check("lit_overflow", 32'(st), 32'd5);
        check("lit_overflow_val", val, 32'd0);
        run_cmd(2'd2, 16'h0117, 16'h0117, 32'd2, 0, st, val);
        check("lit_self_xfer", val, 32'd3);
        run_cmd(2'd2, 16'h0013, 16'h0117, 32'd0, 0, st, val);
        check("lit_zero_xfer", val, 32'd20);
        run_cmd(2'd3, 16'h0013, 16'h0, 32'd0, 10, st, val);
        run_cmd(2'd1, 16'h0117, 16'h0013, 32'd7, 0, st, val);
        check("lit_bad_op", 32'(st), 32'd6);

        do_reset();
        for (int k = 1; k <= 16; k++) run_cmd(2'd0, 16'(k), 16'h0, 32'd1, 0, st, val);
        run_cmd(2'd0, 16'h020C, 16'h0, 32'd100, 0, st, val);
        check("lit_full", 32'(st), 32'd3);
        check("lit_occ16", 32'(occupancy), 32'd16);
        run_cmd(2'd2, 16'h0010, 16'h0001, 32'd1, 0, st, val);
        check("lit_xfer_last_slot", val, 32'd0);

        reset_mid_search(16'h0055, 5);
        run_cmd(2'd3, 16'h0055, 16'h0, 32'd0, 0, st, val);
        check("lit_aborted_issue", 32'(st), 32'd1);

        for (int it = 0; it < 240; it++) begin
            logic [1:0]  op;
            logic [15:0] ka, kb;
            logic [31:0] amt;
            op = 2'($urandom_range(0, 3));
            ka = 16'h0040 + 16'($urandom_range(0, 19));
            kb = 16'h0040 + 16'($urandom_range(0, 19));
            case ($urandom_range(0, 3))
                0: amt = 32'd0;
                1: amt = 32'($urandom_range(0, 50));
                2: amt = 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
                default: amt = $urandom;
            endcase
            run_cmd(op, ka, kb, amt, $urandom_range(0, 3), st, val);
            if (it % 80 == 79) reset_mid_search(ka, $urandom_range(0, 14));
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
